mem_access_ctrl_k2: RTL and testbench
=====================================

MEM_ACCESS_CTRL_K2 -- requirements
Module: mem_access_ctrl_k2

Interface
REQ-001 Parameter: D_WIDTH, default `D_width from the shared package; width of every index, address and stage field.
REQ-002 Parameter: PE_LAT, default 4; butterfly-unit latency in cycles; legal range 1..15.
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 BN_MA_in_en_k2  input  1  the index pair on this cycle is valid.
REQ-006 MA0_idx_k2, MA1_idx_k2  input  D_WIDTH  memory address of butterfly operand 0 / operand 1.
REQ-007 BN0_idx_k2, BN1_idx_k2  input  D_WIDTH  bank number of operand 0 / operand 1; only bit 0 is significant.
REQ-008 AGU_done_in_k2  input  1  single-cycle pulse: the last index pair has been issued.
REQ-009 l_in_k2  input  D_WIDTH  NTT stage number for the current pair.
REQ-010 rd_en_k2  output  1  read strobe to both banks.
REQ-011 rd_addr_b0_k2, rd_addr_b1_k2  output  D_WIDTH  read address for bank 0 / bank 1.
REQ-012 rd_swap_k2  output  1  read-side crossbar select: 1 means bank 0 data feeds operand 1.
REQ-013 wr_en_k2  output  1  write strobe to both banks.
REQ-014 wr_addr_b0_k2, wr_addr_b1_k2  output  D_WIDTH  write address for bank 0 / bank 1.
REQ-015 wr_swap_k2  output  1  write-side crossbar select.
REQ-016 wr_l_k2  output  D_WIDTH  stage number travelling with the write.
REQ-017 busy_k2  output  1  high whenever the FSM is not in IDLE.
REQ-018 ntt_done_k2  output  1  single-cycle pulse when the last write has been issued.
REQ-019 conflict_err_k2  output  1  sticky error flag.

Function
REQ-020 FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on BN_MA_in_en_k2.
- RUN -> DRAIN on AGU_done_in_k2.
- DRAIN -> DONE when the write pipeline is empty.
- DONE -> IDLE unconditionally after one cycle.
REQ-021 Accepted pairs:
- A pair is accepted when BN_MA_in_en_k2=1 and the state is IDLE or RUN.
- In IDLE, the pair that causes the transition is itself accepted.
REQ-022 Read-side mapping, for an accepted pair:
- BN0_idx_k2[0]=0: rd_addr_b0_k2=MA0, rd_addr_b1_k2=MA1, rd_swap_k2=0.
- Otherwise: rd_addr_b0_k2=MA1, rd_addr_b1_k2=MA0, rd_swap_k2=1.
REQ-023 Read outputs are registered with 1-cycle latency from the accepted pair. rd_en_k2 is 0 on cycles with no accepted pair. Read addresses and rd_swap_k2 hold their last value when rd_en_k2=0.
REQ-024 Bank conflict:
- Condition: BN0_idx_k2[0]==BN1_idx_k2[0] on an accepted pair.
- Effect: conflict_err_k2 is set and stays set until rst.
- The pair is still issued using the REQ-022 mapping.
REQ-025 Write side:
- wr_en_k2, wr_addr_b0/b1_k2, wr_swap_k2 and wr_l_k2 reproduce the read-side values delayed by exactly PE_LAT cycles after rd_en_k2.
- Total latency from the accepted pair is PE_LAT+1.
- wr_l_k2 is the l_in_k2 captured with the pair.
REQ-026 The write delay line is a PE_LAT-deep shift register; it sustains one pair per cycle with no back-pressure.
REQ-027 AGU_done_in_k2 and BN_MA_in_en_k2 high in the same cycle: the pair is accepted, then the FSM enters DRAIN.
REQ-028 BN_MA_in_en_k2=1 while in DRAIN or DONE: the pair is ignored and conflict_err_k2 is set.
REQ-029 AGU_done_in_k2 while in IDLE: ignored.
REQ-030 The pipeline is empty when no valid bit is set in the delay line and rd_en_k2=0. DONE is entered on the cycle after the last wr_en_k2, so ntt_done_k2 is high one cycle after the final write.
REQ-031 busy_k2 is high in RUN, DRAIN and DONE.

Reset
REQ-032 With rst=1 at a clock edge:
- the FSM goes to IDLE;
- all outputs go to 0, including conflict_err_k2;
- all delay-line valid bits clear.
REQ-033 rst during RUN or DRAIN abandons in-flight writes; no wr_en_k2 is produced after reset deasserts until a new pair is accepted.

Structure
REQ-034 Shared package holds the D_width constant, the FSM state enum and a packed delay-line entry typedef {valid, addr_b0, addr_b1, swap, l}.
REQ-035 The delay line is one sub-module, wb_delay_line_k2, parameterised by depth and entry type; FSM and mapping stay in the top.

Verification
REQ-036 Single pair: MA0=5, MA1=9, BN0=1, BN1=0 -> next cycle rd_en=1, rd_addr_b0=9, rd_addr_b1=5, rd_swap=1; with PE_LAT=4, wr_en=1 five cycles after input with the same addresses.
REQ-037 Stream of 8 back-to-back pairs, l=3, AGU_done on the 8th -> 8 consecutive wr_en with wr_l=3; ntt_done one cycle after the 8th write; busy low the cycle after ntt_done.
REQ-038 Conflict: BN0=BN1=0 -> conflict_err=1 and stays 1 through ntt_done until rst.
REQ-039 Pair presented in DRAIN -> no rd_en and no wr_en for it; conflict_err=1.
REQ-040 rst asserted 2 cycles after the first pair -> all outputs 0 on the next cycle; no wr_en appears in the following 10 cycles.

Source files
------------

// File: rtl/mem_access_ctrl_k2_pkg.sv
// Shared types for the NTT memory access controller.
// Holds the default index width, FSM encoding and delay-line entry.
package mem_access_ctrl_k2_pkg;

  localparam int D_width = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [D_width-1:0] addr_b0;
    logic [D_width-1:0] addr_b1;
    logic               swap;
    logic [D_width-1:0] l;
  } dl_entry_t;

endpackage

// File: rtl/mem_access_ctrl_k2_wb_delay_line.sv
// Fixed-depth write-back delay line matching the butterfly latency.
// Accepts one entry per cycle; no back-pressure.
module wb_delay_line_k2
  import mem_access_ctrl_k2_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = dl_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  T     din,
  output T     dout,
  output logic pend
);

  T pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

  // Valid entries still behind the output stage.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++)
      pend = pend | pipe[i].valid;
  end

endmodule

// File: rtl/mem_access_ctrl_k2.sv
// Bank-mapped read issue and delayed write-back for the NTT datapath.
// FSM tracks the stream from first pair to final write.
module mem_access_ctrl_k2
  import mem_access_ctrl_k2_pkg::*;
#(
  parameter int D_WIDTH = D_width,
  parameter int PE_LAT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               BN_MA_in_en_k2,
  input  logic [D_WIDTH-1:0] MA0_idx_k2,
  input  logic [D_WIDTH-1:0] MA1_idx_k2,
  input  logic [D_WIDTH-1:0] BN0_idx_k2,
  input  logic [D_WIDTH-1:0] BN1_idx_k2,
  input  logic               AGU_done_in_k2,
  input  logic [D_WIDTH-1:0] l_in_k2,
  output logic               rd_en_k2,
  output logic [D_WIDTH-1:0] rd_addr_b0_k2,
  output logic [D_WIDTH-1:0] rd_addr_b1_k2,
  output logic               rd_swap_k2,
  output logic               wr_en_k2,
  output logic [D_WIDTH-1:0] wr_addr_b0_k2,
  output logic [D_WIDTH-1:0] wr_addr_b1_k2,
  output logic               wr_swap_k2,
  output logic [D_WIDTH-1:0] wr_l_k2,
  output logic               busy_k2,
  output logic               ntt_done_k2,
  output logic               conflict_err_k2
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  typedef struct packed {
    logic               valid;
    logic [D_WIDTH-1:0] addr_b0;
    logic [D_WIDTH-1:0] addr_b1;
    logic               swap;
    logic [D_WIDTH-1:0] l;
  } ent_t;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               accept;
  logic               late_in;
  logic               bank_hit;
  logic [D_WIDTH-1:0] rd_l;
  logic               pend;
  ent_t               dl_in;
  ent_t               dl_out;

  logic unused_bn;
  assign unused_bn = ^{BN0_idx_k2[D_WIDTH-1:1],
                       BN1_idx_k2[D_WIDTH-1:1]};

  assign accept   = BN_MA_in_en_k2 &
                    ((state == IDLE) | (state == RUN));
  assign late_in  = BN_MA_in_en_k2 &
                    ((state == DRAIN) | (state == DONE));
  assign bank_hit = accept &
                    (BN0_idx_k2[0] == BN1_idx_k2[0]);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (BN_MA_in_en_k2) state_nxt = RUN;
      RUN:   if (AGU_done_in_k2) state_nxt = DRAIN;
      // Leave once the output stage holds the last write.
      DRAIN: if (!pend && !rd_en_k2) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_k2      <= 1'b0;
      rd_addr_b0_k2 <= '0;
      rd_addr_b1_k2 <= '0;
      rd_swap_k2    <= 1'b0;
      rd_l          <= '0;
    end else begin
      rd_en_k2 <= accept;
      if (accept) begin
        rd_swap_k2 <= BN0_idx_k2[0];
        rd_l       <= l_in_k2;
        if (BN0_idx_k2[0]) begin
          rd_addr_b0_k2 <= MA1_idx_k2;
          rd_addr_b1_k2 <= MA0_idx_k2;
        end else begin
          rd_addr_b0_k2 <= MA0_idx_k2;
          rd_addr_b1_k2 <= MA1_idx_k2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      conflict_err_k2 <= 1'b0;
    else if (bank_hit || late_in)
      conflict_err_k2 <= 1'b1;
  end

  always_comb begin
    dl_in         = '0;
    dl_in.valid   = rd_en_k2;
    dl_in.addr_b0 = rd_addr_b0_k2;
    dl_in.addr_b1 = rd_addr_b1_k2;
    dl_in.swap    = rd_swap_k2;
    dl_in.l       = rd_l;
  end

  wb_delay_line_k2 #(
    .DEPTH (PE_LAT),
    .T     (ent_t)
  ) u_dl (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out),
    .pend (pend)
  );

  assign wr_en_k2      = dl_out.valid;
  assign wr_addr_b0_k2 = dl_out.addr_b0;
  assign wr_addr_b1_k2 = dl_out.addr_b1;
  assign wr_swap_k2    = dl_out.swap;
  assign wr_l_k2       = dl_out.l;

  assign busy_k2     = (state != IDLE);
  assign ntt_done_k2 = (state == DONE);

endmodule

// File: tb/tb_mem_access_ctrl_k2.sv
// Directed-step bench for mem_access_ctrl_k2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_access_ctrl_k2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ma0, ma1, bn0, bn1, l_in;
  logic       agu_done;
  logic       rd_en, rd_swap, wr_en, wr_swap;
  logic [7:0] rd_b0, rd_b1, wr_b0, wr_b1, wr_l;
  logic       busy, ntt_done, conflict;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl_k2 #(.D_WIDTH(8), .PE_LAT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .BN_MA_in_en_k2  (en),
    .MA0_idx_k2      (ma0),
    .MA1_idx_k2      (ma1),
    .BN0_idx_k2      (bn0),
    .BN1_idx_k2      (bn1),
    .AGU_done_in_k2  (agu_done),
    .l_in_k2         (l_in),
    .rd_en_k2        (rd_en),
    .rd_addr_b0_k2   (rd_b0),
    .rd_addr_b1_k2   (rd_b1),
    .rd_swap_k2      (rd_swap),
    .wr_en_k2        (wr_en),
    .wr_addr_b0_k2   (wr_b0),
    .wr_addr_b1_k2   (wr_b1),
    .wr_swap_k2      (wr_swap),
    .wr_l_k2         (wr_l),
    .busy_k2         (busy),
    .ntt_done_k2     (ntt_done),
    .conflict_err_k2 (conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pair(input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] l);
    en = 1'b1; ma0 = a0; ma1 = a1; bn0 = b0; bn1 = b1; l_in = l;
  endtask

  initial begin
    int         got;
    int         wcnt;
    logic [7:0] exp_b0, exp_b1, last_b0;

    rst = 1'b1; en = 1'b0; agu_done = 1'b0;
    ma0 = '0; ma1 = '0; bn0 = '0; bn1 = '0; l_in = '0;
    repeat (2) tick();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_b0", rd_b0, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", ntt_done, 0);
    chk("rst_conflict", conflict, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Single swapped pair
    set_pair(8'd5, 8'd9, 8'd1, 8'd0, 8'd2);
    tick();
    en = 1'b0;
    chk("p1_rd_en", rd_en, 1);
    chk("p1_rd_b0", rd_b0, 9);
    chk("p1_rd_b1", rd_b1, 5);
    chk("p1_rd_swap", rd_swap, 1);
    chk("p1_busy", busy, 1);
    chk("p1_conflict", conflict, 0);
    repeat (3) tick();
    chk("p1_wr_early", wr_en, 0);
    chk("p1_rd_hold_b0", rd_b0, 9);
    chk("p1_rd_en_low", rd_en, 0);
    tick();
    chk("p1_wr_en", wr_en, 1);
    chk("p1_wr_b0", wr_b0, 9);
    chk("p1_wr_b1", wr_b1, 5);
    chk("p1_wr_swap", wr_swap, 1);
    chk("p1_wr_l", wr_l, 2);
    agu_done = 1'b1;
    tick();
    agu_done = 1'b0;
    chk("p1_wr_off", wr_en, 0);
    chk("p1_drain_busy", busy, 1);
    chk("p1_drain_nodone", ntt_done, 0);
    tick();
    chk("p1_done", ntt_done, 1);
    tick();
    chk("p1_done_pulse", ntt_done, 0);
    chk("p1_idle", busy, 0);

    // Eight back-to-back pairs, done with the last
    for (int i = 0; i < 8; i++) begin
      set_pair(8'(i), 8'(i + 16), 8'(i & 1), 8'((i & 1) ^ 1), 8'd3);
      agu_done = (i == 7);
      tick();
      exp_b0 = (i & 1) ? 8'(i + 16) : 8'(i);
      chk("s_rd_en", rd_en, 1);
      chk("s_rd_b0", rd_b0, exp_b0);
      if (i >= 4) begin
        exp_b0 = ((i - 4) & 1) ? 8'(i - 4 + 16) : 8'(i - 4);
        chk("s_wr_en", wr_en, 1);
        chk("s_wr_b0", wr_b0, exp_b0);
      end
    end
    en = 1'b0; agu_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_b0 = ((k + 4) & 1) ? 8'(k + 20) : 8'(k + 4);
      exp_b1 = ((k + 4) & 1) ? 8'(k + 4) : 8'(k + 20);
      chk("s_wr_en_tail", wr_en, 1);
      chk("s_wr_b0_tail", wr_b0, exp_b0);
      chk("s_wr_b1_tail", wr_b1, exp_b1);
      chk("s_wr_l", wr_l, 3);
      chk("s_nodone", ntt_done, 0);
    end
    tick();
    chk("s_done", ntt_done, 1);
    chk("s_wr_off", wr_en, 0);
    tick();
    chk("s_idle", busy, 0);
    chk("s_no_conflict", conflict, 0);

    // Same-bank pair raises the sticky error
    set_pair(8'd2, 8'd3, 8'd0, 8'd0, 8'd1);
    tick();
    en = 1'b0;
    chk("c_conflict", conflict, 1);
    chk("c_rd_en", rd_en, 1);
    chk("c_rd_b0", rd_b0, 2);
    chk("c_rd_swap", rd_swap, 0);
    agu_done = 1'b1;
    tick();
    agu_done = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      tick();
      if (ntt_done) got = 1;
    end
    chk("c_done_seen", got, 1);
    chk("c_conflict_at_done", conflict, 1);
    tick();
    chk("c_conflict_after", conflict, 1);
    chk("c_idle", busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c_rst_clear", conflict, 0);

    // Pair presented during DRAIN is dropped
    set_pair(8'd1, 8'd2, 8'd0, 8'd1, 8'd0);
    tick();
    en = 1'b0; agu_done = 1'b1;
    tick();
    agu_done = 1'b0;
    set_pair(8'd7, 8'd8, 8'd0, 8'd1, 8'd0);
    tick();
    en = 1'b0;
    chk("d_rd_en", rd_en, 0);
    chk("d_rd_hold", rd_b0, 1);
    chk("d_conflict", conflict, 1);
    wcnt = 0; last_b0 = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (wr_en) begin
        wcnt++;
        last_b0 = wr_b0;
      end
    end
    chk("d_wr_count", wcnt, 1);
    chk("d_wr_b0", last_b0, 1);
    chk("d_idle", busy, 0);

    // Reset two cycles after the first pair
    set_pair(8'd4, 8'd6, 8'd0, 8'd1, 8'd5);
    tick();
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_rd_en", rd_en, 0);
    chk("r_rd_b0", rd_b0, 0);
    chk("r_rd_b1", rd_b1, 0);
    chk("r_wr_en", wr_en, 0);
    chk("r_busy", busy, 0);
    chk("r_conflict", conflict, 0);
    wcnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (wr_en) wcnt++;
    end
    chk("r_no_wr", wcnt, 0);
    chk("r_still_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
